// File: rtl/irq_controller.sv
// 68000 autovector interrupt controller: maps up to four raw event lines onto IPL levels 1..3,
// with per-channel polarity, pending/overflow flags and a tick timestamp of the first event.
module irq_controller #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         wr,
  input  logic [3:0]         address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic [NUM_SRC-1:0] src,
  input  logic [31:0]        ticks,
  input  logic               iack,
  input  logic [2:0]         iack_level,
  output logic [2:0]         ipl_n
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] src_s;
  logic [15:0]        ctrl_q, ctrl_d;
  logic [2:0]         pend_q, pend_d, ovf_q, ovf_d, prev_q, prev_d, ipl_n_q, ipl_n_d;
  logic [31:0]        stamp_q [3];
  logic [2:0]         stamp_en, sig, edge_det, pend_clr, ovf_clr, level;
  logic               iack_q;

  // Selector values outside 1..NUM_SRC mean "none" and force the channel low, ignoring invert.
  function automatic logic chan_sig(input logic [15:0] ctrl, input int unsigned c,
                                    input logic [NUM_SRC-1:0] s);
    logic [2:0] sel;
    logic       v;
    sel = ctrl[4*c +: 3];
    v   = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == k + 1) v = s[k] ^ ctrl[4*c+3];
    end
    return v;
  endfunction

  assign src_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    ctrl_d = ctrl_q;
    if (address == 4'd0) begin
      if (wr[0]) ctrl_d[7:0]  = din[7:0];
      if (wr[1]) ctrl_d[15:8] = din[15:8] & 8'h8f;
    end

    pend_clr = '0;
    ovf_clr  = '0;
    if (wr[0] && address == 4'd1) pend_clr = din[2:0];
    if (wr[0] && address == 4'd2) ovf_clr  = din[2:0];
    if (iack && !iack_q && iack_level != 3'd0 && iack_level <= 3'd3) begin
      pend_clr[iack_level[1:0] - 2'd1] = 1'b1;
    end

    for (int unsigned c = 0; c < 3; c++) sig[c] = chan_sig(ctrl_q, c, src_s);
    edge_det = sig & ~prev_q;

    // Reconfigured channels restart from their new level so a CTRL write never fakes an edge.
    prev_d = sig;
    if (address == 4'd0 && wr[0]) begin
      prev_d[0] = chan_sig(ctrl_d, 0, src_s);
      prev_d[1] = chan_sig(ctrl_d, 1, src_s);
    end
    if (address == 4'd0 && wr[1]) prev_d[2] = chan_sig(ctrl_d, 2, src_s);

    // A new event beats a same-cycle clear; otherwise an event on a pending channel overflows.
    stamp_en = edge_det & (~pend_q | pend_clr);
    pend_d   = edge_det | (pend_q & ~pend_clr);
    ovf_d    = (edge_det & pend_q & ~pend_clr) | (ovf_q & ~ovf_clr);

    if (pend_q[2])      level = 3'd3;
    else if (pend_q[1]) level = 3'd2;
    else if (pend_q[0]) level = 3'd1;
    else                level = 3'd0;

    ipl_n_d = ipl_n_q;
    if (!iack) ipl_n_d = ctrl_q[15] ? ~level : 3'b111;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int unsigned c = 0; c < 3; c++) stamp_q[c] <= '0;
      ctrl_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      prev_q  <= '0;
      ipl_n_q <= 3'b111;
      iack_q  <= 1'b0;
    end else begin
      sync_q[0] <= src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int unsigned c = 0; c < 3; c++) begin
        if (stamp_en[c]) stamp_q[c] <= ticks;
      end
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
      ipl_n_q <= ipl_n_d;
      iack_q  <= iack;
    end
  end

  assign ipl_n = ipl_n_q;

  always_comb begin
    dout = '0;
    case (address)
      4'd0:    dout = ctrl_q;
      4'd1:    dout = {13'd0, pend_q};
      4'd2:    dout = {13'd0, ovf_q};
      4'd4:    dout = stamp_q[0][31:16];
      4'd5:    dout = stamp_q[0][15:0];
      4'd6:    dout = stamp_q[1][31:16];
      4'd7:    dout = stamp_q[1][15:0];
      4'd8:    dout = stamp_q[2][31:16];
      4'd9:    dout = stamp_q[2][15:0];
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic against a behavioural
// model of channel levels, pending/overflow flags, stamps and IPL.
`timescale 1ns/100ps
module tb_irq_controller;
  localparam int NS = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    wr = '0;
  logic [3:0]    address = '0;
  logic [15:0]   din = '0;
  logic [15:0]   dout;
  logic [NS-1:0] src = '0;
  logic [31:0]   ticks = 32'h0000_1000;
  logic          iack = 1'b0;
  logic [2:0]    iack_level = '0;
  logic [2:0]    ipl_n;

  int n_chk = 0;
  int n_fail = 0;
  bit tick_run = 1'b1;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .address(address), .din(din), .dout(dout),
    .src(src), .ticks(ticks), .iack(iack), .iack_level(iack_level), .ipl_n(ipl_n)
  );

  // Behavioural model: src samples become visible SS clocks after they are taken.
  logic [NS-1:0] hist[$];
  logic [15:0]   m_ctrl;
  logic [2:0]    m_pend, m_ovf, m_prev, m_ipl;
  logic [31:0]   m_stamp [3];
  logic          m_iack;

  function automatic logic level_of(input logic [15:0] ctrl, input int c, input logic [NS-1:0] s);
    int sel;
    sel = int'(ctrl[4*c +: 3]);
    if (sel >= 1 && sel <= NS) return s[sel-1] ^ ctrl[4*c+3];
    return 1'b0;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    case (a)
      4'd0: return m_ctrl;
      4'd1: return {13'd0, m_pend};
      4'd2: return {13'd0, m_ovf};
      4'd4: return m_stamp[0][31:16];
      4'd5: return m_stamp[0][15:0];
      4'd6: return m_stamp[1][31:16];
      4'd7: return m_stamp[1][15:0];
      4'd8: return m_stamp[2][31:16];
      4'd9: return m_stamp[2][15:0];
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (SS) hist.push_back('0);
    m_ctrl = '0; m_pend = '0; m_ovf = '0; m_prev = '0; m_ipl = 3'b111; m_iack = 1'b0;
    for (int c = 0; c < 3; c++) m_stamp[c] = '0;
  endtask

  // One clock: model evaluates the inputs held before the edge, then inputs may change.
  task automatic cyc();
    logic [NS-1:0] syn;
    logic [2:0] sig, edg, clr, oclr, nprev, npend, novf, nipl;
    logic [15:0] nctrl;
    int top;
    if (!reset_n) begin
      @(posedge clk);
      model_reset();
    end else begin
      syn = hist[0];
      for (int c = 0; c < 3; c++) sig[c] = level_of(m_ctrl, c, syn);
      edg = sig & ~m_prev;
      clr = '0;
      oclr = '0;
      if (iack && !m_iack && iack_level >= 1 && iack_level <= 3) clr[iack_level-1] = 1'b1;
      if (wr[0] && address == 4'd1) clr = clr | din[2:0];
      if (wr[0] && address == 4'd2) oclr = din[2:0];
      nctrl = m_ctrl;
      if (address == 4'd0 && wr[0]) nctrl[7:0] = din[7:0];
      if (address == 4'd0 && wr[1]) nctrl[15:8] = {din[15], 3'b000, din[11:8]};
      for (int c = 0; c < 3; c++) begin
        nprev[c] = sig[c];
        if (address == 4'd0 && ((c < 2 && wr[0]) || (c == 2 && wr[1])))
          nprev[c] = level_of(nctrl, c, syn);
      end
      top = m_pend[2] ? 3 : m_pend[1] ? 2 : m_pend[0] ? 1 : 0;
      nipl = iack ? m_ipl : (m_ctrl[15] ? ~3'(top) : 3'b111);
      npend = edg | (m_pend & ~clr);
      novf = (edg & m_pend & ~clr) | (m_ovf & ~oclr);
      @(posedge clk);
      for (int c = 0; c < 3; c++) if (edg[c] && (!m_pend[c] || clr[c])) m_stamp[c] = ticks;
      m_ctrl = nctrl; m_pend = npend; m_ovf = novf; m_prev = nprev; m_ipl = nipl;
      m_iack = iack;
      hist.push_back(src);
      void'(hist.pop_front());
    end
    #1;
    if (tick_run) ticks = ticks + 32'd1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    address = a;
    #1;
    d = dout;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    address = a; din = d; wr = be;
    cyc();
    wr = '0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    for (int a = 0; a < 16; a++) begin
      src = NS'($urandom);
      cyc();
      rd(4'(a), d);
      n_chk++;
      if (d !== 16'd0) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want 0000", a, d); end
      n_chk++;
      if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL reset_ipl: got %b want 111", ipl_n); end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      src = NS'($urandom);
      cyc();
      rd(4'd1, d);
      n_chk++;
      if (d !== 16'd0 || ipl_n !== 3'b111) begin
        n_fail++; $display("FAIL idle_ctrl0: pend %h ipl %b want 0000/111", d, ipl_n);
      end
    end
  endtask

  task automatic test_single_event();
    logic [15:0] d;
    int k;
    src = '0;
    repeat (4) cyc();
    wr_reg(4'd0, 16'h8001, 2'b11);
    tick_run = 1'b0;
    ticks = 32'h1234_5678;
    src[0] = 1'b1;
    k = 0;
    d = '0;
    while (d == 16'd0 && k < 10) begin
      cyc();
      k++;
      rd(4'd1, d);
    end
    n_chk++;
    if (k !== SS + 1 || d !== 16'h0001) begin
      n_fail++; $display("FAIL single_latency: pend %h after %0d clocks want 0001 after %0d", d, k, SS + 1);
    end
    n_chk++;
    if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL single_ipl_early: got %b want 111", ipl_n); end
    cyc();
    n_chk++;
    if (ipl_n !== 3'b110) begin n_fail++; $display("FAIL single_ipl: got %b want 110", ipl_n); end
    rd(4'd4, d);
    n_chk++;
    if (d !== 16'h1234) begin n_fail++; $display("FAIL stamp0_hi: got %h want 1234", d); end
    rd(4'd5, d);
    n_chk++;
    if (d !== 16'h5678) begin n_fail++; $display("FAIL stamp0_lo: got %h want 5678", d); end
    tick_run = 1'b1;
  endtask

  task automatic test_priority_iack();
    logic [15:0] d;
    wr_reg(4'd1, 16'h0007, 2'b01);
    wr_reg(4'd2, 16'h0007, 2'b01);
    src = '0;
    repeat (4) cyc();
    wr_reg(4'd0, 16'h8301, 2'b11);
    src = 4'b0101;
    repeat (5) cyc();
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0005 || ipl_n !== 3'b100) begin
      n_fail++; $display("FAIL prio_two: pend %h ipl %b want 0005/100", d, ipl_n);
    end
    iack = 1'b1; iack_level = 3'd3;
    cyc();
    cyc();
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0001 || ipl_n !== 3'b100) begin
      n_fail++; $display("FAIL iack3_frozen: pend %h ipl %b want 0001/100", d, ipl_n);
    end
    iack = 1'b0;
    cyc();
    n_chk++;
    if (ipl_n !== 3'b110) begin n_fail++; $display("FAIL iack3_ipl: got %b want 110", ipl_n); end
    iack = 1'b1; iack_level = 3'd1;
    cyc();
    iack = 1'b0;
    cyc();
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0000 || ipl_n !== 3'b111) begin
      n_fail++; $display("FAIL iack1: pend %h ipl %b want 0000/111", d, ipl_n);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic [31:0] first;
    src = '0;
    repeat (4) cyc();
    wr_reg(4'd0, 16'h8020, 2'b11);
    src[1] = 1'b1;
    repeat (5) cyc();
    first = m_stamp[1];
    src[1] = 1'b0;
    repeat (3) cyc();
    src[1] = 1'b1;
    repeat (5) cyc();
    rd(4'd2, d);
    n_chk++;
    if (d !== 16'h0002) begin n_fail++; $display("FAIL ovf_set: got %h want 0002", d); end
    rd(4'd6, d);
    n_chk++;
    if (d !== first[31:16]) begin n_fail++; $display("FAIL ovf_stamp_hi: got %h want %h", d, first[31:16]); end
    rd(4'd7, d);
    n_chk++;
    if (d !== first[15:0]) begin n_fail++; $display("FAIL ovf_stamp_lo: got %h want %h", d, first[15:0]); end
    wr_reg(4'd2, 16'h0002, 2'b01);
    rd(4'd2, d);
    n_chk++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL ovf_w1c: got %h want 0000", d); end
  endtask

  task automatic test_collision_invert();
    logic [15:0] d;
    logic [31:0] t_exp;
    src = '0;
    repeat (4) cyc();
    wr_reg(4'd0, 16'h8001, 2'b11);
    wr_reg(4'd1, 16'h0007, 2'b01);
    wr_reg(4'd2, 16'h0007, 2'b01);
    src[0] = 1'b1;
    repeat (5) cyc();
    src[0] = 1'b0;
    repeat (3) cyc();
    src[0] = 1'b1;
    cyc();
    cyc();
    t_exp = ticks;
    wr_reg(4'd1, 16'h0001, 2'b01);
    rd(4'd1, d);
    n_chk++;
    if (d[0] !== 1'b1) begin n_fail++; $display("FAIL collide_pend: got %h want bit0 set", d); end
    rd(4'd5, d);
    n_chk++;
    if (d !== t_exp[15:0]) begin n_fail++; $display("FAIL collide_stamp: got %h want %h", d, t_exp[15:0]); end
    rd(4'd2, d);
    n_chk++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL collide_ovf: got %h want 0000", d); end
    src[0] = 1'b0;
    repeat (4) cyc();
    wr_reg(4'd1, 16'h0001, 2'b01);
    wr_reg(4'd0, 16'h8009, 2'b11);
    repeat (5) cyc();
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL invert_no_edge: got %h want 0000", d); end
  endtask

  task automatic test_disable();
    logic [15:0] d;
    src = '0;
    wr_reg(4'd0, 16'h0001, 2'b11);
    wr_reg(4'd1, 16'h0007, 2'b01);
    src[0] = 1'b1;
    repeat (5) cyc();
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0001 || ipl_n !== 3'b111) begin
      n_fail++; $display("FAIL disabled: pend %h ipl %b want 0001/111", d, ipl_n);
    end
    wr_reg(4'd0, 16'h8001, 2'b11);
    cyc();
    n_chk++;
    if (ipl_n !== 3'b110) begin n_fail++; $display("FAIL enable_ipl: got %b want 110", ipl_n); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL midreset_ipl: got %b want 111", ipl_n); end
    rd(4'd1, d);
    n_chk++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL midreset_pend: got %h want 0000", d); end
    cyc();
    reset_n = 1'b1;
    wr_reg(4'd0, 16'h8001, 2'b11);
    for (int i = 0; i < 6; i++) begin
      cyc();
      rd(4'd1, d);
      n_chk++;
      if (d !== exp_rd(4'd1)) begin n_fail++; $display("FAIL post_reset_pend[%0d]: got %h want %h", i, d, exp_rd(4'd1)); end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [3:0] a;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) src = NS'($urandom);
      iack = ($urandom_range(0, 7) == 0);
      iack_level = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        wr = 2'($urandom_range(1, 3));
        address = 4'($urandom_range(0, 9));
        din = 16'($urandom);
      end
      cyc();
      wr = '0;
      n_chk++;
      if (ipl_n !== m_ipl) begin n_fail++; $display("FAIL rand_ipl[%0d]: got %b want %b", i, ipl_n, m_ipl); end
      a = 4'($urandom_range(0, 15));
      rd(a, d);
      n_chk++;
      if (d !== exp_rd(a)) begin n_fail++; $display("FAIL rand_rd[%0d] addr %0d: got %h want %h", i, a, d, exp_rd(a)); end
    end
    iack = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_event();
    test_priority_iack();
    test_overflow();
    test_collision_invert();
    test_disable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
